ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
PS/2 keyboard receiver. It deserializes device-to-host frames from the keyboard's ps2_clk/ps2_data lines and keeps a 32-bit history of received scan-code bytes. It raises a one-cycle rx_done strobe for each good frame. It is the producer for the game-logic consumers (paddle controllers, match start), which decode data[15:0] / data[7:0] on the system clock.

Parameters:
FILTER_LEN, 8, consecutive clk cycles a synchronized ps2_clk level must hold before the filtered clock changes.
TIMEOUT_CYCLES, 200000, clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted (2 ms at 100 MHz).

Ports:
clk  input  1  system clock (100 MHz).
rst  input  1  asynchronous, active-low reset (0 = reset).
ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk; idles high.
ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clk; idles high.
data  output  32  received byte history; newest byte in [7:0], previous in [15:8], and so on.
rx_done  output  1  one-clk pulse; data was updated with a good byte this cycle.
frame_err  output  1  one-clk pulse on a start, parity, stop or timeout error.
busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async): data=32'h0, rx_done=0, frame_err=0, busy=0, state=IDLE, filtered clock=1, shift register=0, bit and timeout counters=0, both sync chains=1.
- Synchronization: ps2_clk and ps2_data each pass through a 2-FF synchronizer into the clk domain.
- Clock filter:
  - Filtered clock takes the synchronized ps2_clk value only after that value has differed from the current filtered value for FILTER_LEN consecutive clk cycles.
  - Any bounce restarts the count.
- Sampling: a falling edge of the filtered clock (1->0, detected with a registered copy) samples the synchronized ps2_data in that same clk cycle.
- Frame format: start(0), D0..D7 (LSB first), odd parity, stop(1). That is 11 falling edges.
- FSM, one transition per sampling edge:
  - IDLE: sampled 0 -> DATA with bit count=0. Sampled 1 -> frame_err pulse, stay IDLE.
  - DATA: shift the bit into shift[7] and shift right. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: good frame if stop=1 and popcount(D0..D7)+parity is odd. Otherwise error. Always -> IDLE.
- Good frame: on the clk after the stop-bit sample, data <= {data[23:0], byte}, rx_done=1 for exactly one cycle, frame_err=0.
- Bad frame (parity or stop error): frame_err=1 for one cycle; data unchanged; rx_done stays 0.
- Timeout:
  - The counter clears on every sampling edge and while IDLE. Otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1 in a non-IDLE state: -> IDLE, partial byte discarded, frame_err pulse, data unchanged.
  - The counter saturates; it does not wrap.
- rx_done and frame_err are never high in the same cycle. Both are registered outputs.
- Reset mid-frame aborts immediately. After rst deasserts, the receiver ignores edges until it sees a fresh start bit in IDLE. It does not resync to a partial frame.
- busy is high from the cycle after the start-bit sample through the STOP-state exit.
- Latency: raw ps2_clk fall -> sample = 2 (sync) + FILTER_LEN + 1 (edge detect) clk cycles. Stop sample -> rx_done = 1 clk.
- Break/extended codes (F0, E0) get no special handling. The byte history is the only record; consumers decode sequences such as 16'hF0xx or 16'h7272 from data.

Test Plan:
- Reset then send good frame 0x72 (bits 0,0100_1110 LSB-first, parity 1, stop 1) -> one rx_done pulse; data=32'h00000072; frame_err never asserted.
- Send 0x72, then 0x72, then 0xF0, then 0x75 -> four rx_done pulses; final data=32'h7272F075; intermediate data[15:0]=16'h7272 after the 2nd byte.
- Send 0x75 with inverted parity -> frame_err pulses once; no rx_done; data unchanged from the previous value.
- Send 4 bits of a frame, then hold ps2_clk high for TIMEOUT_CYCLES+10 clocks -> frame_err pulse; busy falls; a following good frame 0x29 gives data[7:0]=8'h29.
- Inject 3-cycle low glitches on ps2_clk (< FILTER_LEN) between real edges of frame 0x1C -> glitches ignored; data[7:0]=8'h1C; exactly one rx_done.
- Assert rst low mid-frame (after bit 5) -> all outputs 0 asynchronously. Release and send 0x75 -> data=32'h00000075.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// Filters ps2_clk and keeps a 32-bit history of received bytes.
`timescale 1ns/1ps

module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] data,
    output logic        rx_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_tcnt;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bcnt;
    logic [2:0]    w_bcnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_par;
    logic          w_par_nxt;
    logic [31:0]   r_data;
    logic [31:0]   w_data_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_err;
    logic          w_err_nxt;

    logic          w_fall;
    logic          w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Any cycle matching the filtered level restarts the hold count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FMAX) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_fall    = r_filt_d & ~r_filt;
    assign w_timeout = (r_state != IDLE) && (r_tcnt == TMAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
        end else if (r_state == IDLE || w_fall) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TMAX) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (r_dat_s2) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DATA;
                        w_bcnt_nxt  = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {r_dat_s2, r_shift[7:1]};
                    w_bcnt_nxt  = r_bcnt + 3'd1;
                    if (r_bcnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nxt   = r_dat_s2;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    if (r_dat_s2 && (^{r_shift, r_par})) begin
                        w_data_nxt = {r_data[23:0], r_shift};
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bcnt  <= 3'd0;
            r_shift <= 8'h00;
            r_par   <= 1'b0;
            r_data  <= 32'h0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign data      = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed frames, scoreboard queue checked by a
// monitor that pops one expectation per rx_done/frame_err pulse.
`timescale 1ns/1ps

module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] data;
    logic        rx_done;
    logic        frame_err;
    logic        busy;

    typedef struct packed {
        logic        is_err;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_data = 32'h0;

    always #5 clk = ~clk;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .data(data),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rst && (rx_done || frame_err)) begin
            chk("exclusive", {31'b0, rx_done & frame_err}, 32'h0);
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected: rx_done=%b frame_err=%b data=%h expected no event",
                         rx_done, frame_err, data);
            end else begin
                e = q.pop_front();
                chk("kind_err", {31'b0, frame_err}, {31'b0, e.is_err});
                chk("sb_data", data, e.d);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit flip_par,
                             input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                wait_clk(15);
                ps2_clk = 1'b0;
                wait_clk(3);
                ps2_clk = 1'b1;
                wait_clk(HALF - 18);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL %s: %0d events still pending, required 0", name, q.size());
            q.delete();
        end
        wait_clk(2 * HALF);
    endtask

    task automatic send_good(input logic [7:0] b, input bit glitch);
        exp_data = {exp_data[23:0], b};
        q.push_back({1'b0, exp_data});
        send_bits(b, 1'b0, 11, glitch);
        wait_drain("good_frame");
    endtask

    task automatic send_bad(input logic [7:0] b);
        q.push_back({1'b1, exp_data});
        send_bits(b, 1'b1, 11, 1'b0);
        wait_drain("bad_frame");
    endtask

    initial begin
        wait_clk(3);
        #1;
        chk("rst_data", data, 32'h0);
        chk("rst_done", {31'b0, rx_done}, 32'h0);
        chk("rst_err", {31'b0, frame_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(20);

        send_good(8'h72, 1'b0);
        chk("first_72", data, 32'h0000_0072);

        send_good(8'h72, 1'b0);
        chk("hist_7272", {16'h0, data[15:0]}, 32'h0000_7272);
        send_good(8'hF0, 1'b0);
        send_good(8'h75, 1'b0);
        chk("hist_final", data, 32'h7272_F075);

        send_bad(8'h75);
        chk("bad_par_data", data, 32'h7272_F075);

        q.push_back({1'b1, exp_data});
        send_bits(8'hA5, 1'b0, 4, 1'b0);
        chk("busy_partial", {31'b0, busy}, 32'h1);
        wait_clk(TO + 10);
        wait_drain("timeout");
        chk("busy_after_to", {31'b0, busy}, 32'h0);
        send_good(8'h29, 1'b0);
        chk("after_to_29", {24'h0, data[7:0]}, 32'h0000_0029);

        send_good(8'h1C, 1'b1);
        chk("glitch_1C", {24'h0, data[7:0]}, 32'h0000_001C);

        send_bits(8'h55, 1'b0, 6, 1'b0);
        chk("busy_pre_rst", {31'b0, busy}, 32'h1);
        wait_clk(5);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_data", data, 32'h0);
        chk("mid_rst_done", {31'b0, rx_done}, 32'h0);
        chk("mid_rst_err", {31'b0, frame_err}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        exp_data = 32'h0;
        wait_clk(5);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(20);
        send_good(8'h75, 1'b0);
        chk("post_rst_75", data, 32'h0000_0075);

        chk("sb_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
